// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake and a shift-add multiplier (op 6).
// Define SEQ_ALU_HEX_EN to drive the seven-segment hex output; otherwise hex is blank.
module seq_alu #(
    parameter  int WIDTH  = 4,
    localparam int DIGITS = (2*WIDTH+3)/4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  cin,
    input  logic [2:0]            op,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [2*WIDTH-1:0]    result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  zero,
    output logic [7*DIGITS-1:0]   hex
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_next;

    logic [2*WIDTH-1:0] mcand, prod, prod_next, alu_val;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               accept, last_iter;

    function automatic int unsigned ones(input logic [WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    assign busy      = (state == MUL);
    assign in_ready  = !busy && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_iter = busy && (cnt == CW'(WIDTH-1));
    assign prod_next = prod + (mplier[0] ? mcand : '0);
    assign zero      = (result == '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && op == 3'd6) state_next = MUL;
            MUL:  if (last_iter)            state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_val = '0;
        case (op)
            3'd0: alu_val = (2*WIDTH)'(a) + (2*WIDTH)'(b) + (2*WIDTH)'(cin);
            3'd1: alu_val = {{(WIDTH-1){1'b0}}, (a < b), a - b};
            3'd2: alu_val = {a ^ b, a | b};
            3'd3: alu_val = (|{a, b}) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : '0;
            3'd4: alu_val = (ones(a) == 1 && ones(b) == 2) ? {a, b} : '0;
            3'd5: alu_val = {a, ~b};
            3'd7: alu_val = result + (2*WIDTH)'(a);
            default: alu_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            result    <= '0;
            out_valid <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            if (busy) begin
                prod   <= prod_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            // Operands are latched here so later input changes cannot disturb MUL.
            if (accept && op == 3'd6) begin
                mcand  <= (2*WIDTH)'(a);
                mplier <= b;
                prod   <= '0;
                cnt    <= '0;
            end
            if (last_iter) begin
                result    <= prod_next;
                out_valid <= 1'b1;
            end else if (accept && op != 3'd6) begin
                result    <= alu_val;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SEQ_ALU_HEX_EN
    logic [4*DIGITS-1:0] padded;

    always_comb begin
        padded                = '0;
        padded[2*WIDTH-1:0]   = result;
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign hex[7*i +: 7] = seg7(padded[4*i +: 4]);
    end
`else
    assign hex = '1;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4): directed cases then random traffic vs. a transaction-level model.
module tb_seq_alu;
    logic        clock, resetn, cin, in_valid, in_ready, out_valid, out_ready, busy, zero;
    logic [3:0]  a, b;
    logic [2:0]  op;
    logic [7:0]  result;
    logic [13:0] hex;

    int checks = 0, failures = 0;

    logic [7:0] m_result, m_mul;
    bit         m_valid;
    int         m_left;

    seq_alu #(.WIDTH(4)) dut (
        .clock(clock), .resetn(resetn), .a(a), .b(b), .cin(cin), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .zero(zero), .hex(hex)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [13:0] exp_hex(input logic [7:0] r);
`ifdef SEQ_ALU_HEX_EN
        return {glyph(r[7:4]), glyph(r[3:0])};
`else
        return 14'h3FFF;
`endif
    endfunction

    function automatic logic [7:0] alu_ref(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                                           input logic c, input logic [7:0] cur);
        logic [3:0] d;
        d = x - y;
        case (o)
            3'd0: return 8'(x) + 8'(y) + 8'(c);
            3'd1: return {3'b000, x < y, d};
            3'd2: return {x ^ y, x | y};
            3'd3: return ((x | y) != 0) ? 8'h0F : 8'h00;
            3'd4: return ($countones(x) == 1 && $countones(y) == 2) ? {x, y} : 8'h00;
            3'd5: return {x, ~y};
            3'd7: return cur + 8'(x);
            default: return 8'(x) * 8'(y);
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".result"},    32'(result),    32'(m_result));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".busy"},      32'(busy),      32'(m_left > 0));
        check({tag, ".zero"},      32'(zero),      32'(m_result == 8'h00));
        check({tag, ".hex"},       32'(hex),       32'(exp_hex(m_result)));
    endtask

    // One clock: check in_ready against current inputs, advance model over the edge, check outputs.
    task automatic step(input string tag);
        bit exp_ready, acc;
        #1;
        exp_ready = (m_left == 0) && (!m_valid || out_ready);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
        acc = in_valid && exp_ready;
        @(posedge clock);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_result = m_mul;
                m_valid  = 1'b1;
            end else if (out_ready) m_valid = 1'b0;
        end else if (acc) begin
            if (op == 3'd6) begin
                m_left = 4;
                m_mul  = 8'(a) * 8'(b);
                if (out_ready) m_valid = 1'b0;
            end else begin
                m_result = alu_ref(op, a, b, cin, m_result);
                m_valid  = 1'b1;
            end
        end else if (out_ready) m_valid = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                         input logic c, input logic v, input logic r);
        op = o; a = x; b = y; cin = c; in_valid = v; out_ready = r;
    endtask

    task automatic model_reset();
        m_result = 8'h00; m_valid = 1'b0; m_left = 0;
    endtask

    initial begin
        resetn = 1'b0;
        drive(3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clock); #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check_outputs("reset");
        #2 resetn = 1'b1;

        // ADD with carry-out
        drive(3'd0, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1);
        step("add_carry");
        check("add_carry.value", 32'(result), 32'h11);

        // MUL: inputs scrambled while busy must not matter
        drive(3'd6, 4'hD, 4'hB, 1'b0, 1'b1, 1'b1);
        step("mul_accept");
        for (int i = 0; i < 4; i++) begin
            drive(3'(i), 4'(i * 3), 4'(i + 5), 1'b1, 1'b1, 1'b0);
            step("mul_iter");
        end
        check("mul.value", 32'(result), 32'h8F);

        // Back-pressure: hold then a no-bubble replacement
        drive(3'd0, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0);
        step("bp_first");
        drive(3'd0, 4'h4, 4'h5, 1'b0, 1'b1, 1'b0);
        step("bp_hold");
        step("bp_hold2");
        drive(3'd0, 4'h4, 4'h5, 1'b0, 1'b1, 1'b1);
        step("bp_replace");
        check("bp_replace.value", 32'(result), 32'h09);

        // ACC wraps modulo 2^8
        drive(3'd5, 4'hF, 4'h1, 1'b0, 1'b1, 1'b1);
        step("invlo_fe");
        drive(3'd7, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1);
        step("acc_wrap");
        check("acc_wrap.value", 32'(result), 32'h01);

        // PATTERN hit/miss, ANY zero case, SUB borrow, hex glyphs for 3A
        drive(3'd4, 4'h4, 4'h5, 1'b0, 1'b1, 1'b1); step("pattern_hit");
        drive(3'd4, 4'h3, 4'h5, 1'b0, 1'b1, 1'b1); step("pattern_miss");
        drive(3'd3, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1); step("any_zero");
        drive(3'd1, 4'h2, 4'h5, 1'b0, 1'b1, 1'b1); step("sub_borrow");
        drive(3'd2, 4'h2, 4'h1, 1'b0, 1'b1, 1'b1); step("logic_3a");
        check("logic_3a.value", 32'(result), 32'h33);
        drive(3'd5, 4'h3, 4'h5, 1'b0, 1'b1, 1'b1); step("invlo_3a");
        check("invlo_3a.value", 32'(result), 32'h3A);

        // Reset during the second MUL clock abandons the product
        drive(3'd6, 4'h7, 4'h7, 1'b0, 1'b1, 1'b1);
        step("mulrst_accept");
        drive(3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        step("mulrst_iter1");
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check("mulrst.in_ready", 32'(in_ready), 32'd1);
        check_outputs("mulrst");
        @(posedge clock); #2 resetn = 1'b1;
        drive(3'd0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step("mulrst_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL derive localparam DIGITS = (2*WIDTH+3)/4, the number of hex digits covering the result.
REQ-003 The block SHALL use one clock, reset asynchronous and active-low, with ports: clock  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have the following ports:
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for ADD
- op  in  3  operation select
- in_valid  in  1  operands/op offered
- in_ready  out  1  block can accept
- result  out  2*WIDTH  registered result
- out_valid  out  1  result pending
- out_ready  in  1  consumer takes result
- busy  out  1  multicycle op in progress
- zero  out  1  result == 0
- hex  out  7*DIGITS  active-low segments, digit i at [7i+6:7i], bit0=a..bit6=g

Function
REQ-005 An operation SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-006 in_ready SHALL be 1 when state is IDLE and (out_valid == 0 or out_ready == 1), else 0.
REQ-007 The FSM SHALL have states IDLE and MUL; IDLE->MUL on accepting op 6; MUL->IDLE after WIDTH iterations; all other ops stay in IDLE.
REQ-008 Ops 0-5 and 7 SHALL write result and set out_valid on the accepting edge (latency 1).
REQ-009 Op 0 (ADD) SHALL produce zero-extended a+b+cin; bit WIDTH is carry-out.
REQ-010 Op 1 (SUB) SHALL produce result[WIDTH-1:0] = a-b mod 2^WIDTH and result[WIDTH] = borrow (a<b); upper bits 0.
REQ-011 Op 2 (LOGIC) SHALL produce {a^b, a|b}.
REQ-012 Op 3 (ANY) SHALL produce {WIDTH zeros, WIDTH ones} if |{a,b}, else 0.
REQ-013 Op 4 (PATTERN) SHALL produce {a,b} if popcount(a)==1 and popcount(b)==2, else 0.
REQ-014 Op 5 (INVLO) SHALL produce {a, ~b}.
REQ-015 Op 6 (MUL) SHALL compute unsigned a*b by shift-add, one iteration per clock, WIDTH clocks in MUL, with result and out_valid written on the final MUL edge; total latency WIDTH+1 edges from acceptance.
REQ-016 Op 7 (ACC) SHALL produce (current result register + zero-extended a) mod 2^(2*WIDTH), using the register value whether or not it was consumed.
REQ-017 busy SHALL be 1 exactly while state is MUL; in_ready SHALL be 0 while busy.
REQ-018 While out_valid && !out_ready, result SHALL be held stable.
REQ-019 On an edge with out_valid && out_ready and no new acceptance, out_valid SHALL clear; result SHALL retain its value.
REQ-020 On an edge with out_ready and a new acceptance, the new result SHALL replace the old one and out_valid SHALL stay 1 (no bubble).
REQ-021 zero SHALL be combinational (result == 0), independent of out_valid.
REQ-022 In MUL, operands SHALL be captured at acceptance; later changes on a, b and op SHALL be ignored.

Reset
REQ-023 While resetn == 0: state IDLE, result 0, out_valid 0, busy 0, internal multiplier registers 0; in_ready SHALL be 1 and zero SHALL be 1.
REQ-024 Reset asserted mid-MUL SHALL abandon the operation with no result produced after release.

Configuration
REQ-025 Macro SEQ_ALU_HEX_EN defined: each hex digit i SHALL show result[4i+3:4i] as a 0-F glyph, with unused high nibble bits treated as 0.
REQ-026 Macro SEQ_ALU_HEX_EN undefined: no decoders SHALL be instantiated; hex SHALL be all ones (blank), and the port SHALL still exist.

Verification (WIDTH=4)
REQ-027 ADD a=F b=1 cin=1, out_ready=1 -> next edge result=8'h11, out_valid=1, zero=0.
REQ-028 MUL a=D b=B -> busy=1 and in_ready=0 for 4 clocks, then result=8'h8F, out_valid=1, busy=0.
REQ-029 out_ready=0, ADD accepted, second ADD offered -> in_ready=0, result holds; one-cycle out_ready pulse with second op valid -> second result loaded, out_valid stays 1.
REQ-030 Result 8'hFE, then ACC a=3 -> result=8'h01.
REQ-031 resetn low during 2nd MUL clock -> result=0, out_valid=0, busy=0, in_ready=1; no out_valid pulse after release.
REQ-032 Result 8'h3A with SEQ_ALU_HEX_EN -> hex[6:0]=7'b0001000, hex[13:7]=7'b0110000; without macro, hex=14'h3FFF.
